// File: rtl/pwm_pkg.sv
// Shared state encoding and default widths for the PWM driver slice.
package pwm_pkg;

  localparam int PWM_CNT_W = 16;
  localparam int PWM_DT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output stage: blanks both sides for dead_time cycles on every raw edge.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stop,
  input  logic            raw,
  input  logic [DT_W-1:0] dead_time,
  output logic            hi,
  output logic            lo
);

  logic            r_raw_d;
  logic [DT_W-1:0] r_blank;
  logic            r_hi;
  logic            r_lo;

  // Blanking is a down-counter; the driven side is released on its terminal count.
  // A raw edge while blanking reloads the counter, so shoot-through cannot occur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw_d <= 1'b0;
      r_blank <= '0;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
    end else if (stop) begin
      r_raw_d <= raw;
      r_blank <= '0;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
    end else if (raw != r_raw_d) begin
      r_raw_d <= raw;
      if (dead_time == '0) begin
        r_hi    <= raw;
        r_lo    <= ~raw;
        r_blank <= '0;
      end else begin
        r_hi    <= 1'b0;
        r_lo    <= 1'b0;
        r_blank <= dead_time;
      end
    end else if (r_blank != '0) begin
      r_blank <= r_blank - DT_W'(1);
      if (r_blank == DT_W'(1)) begin
        r_hi <= raw;
        r_lo <= ~raw;
      end
    end else begin
      r_hi <= raw;
      r_lo <= ~raw;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: rtl/pwm_driver.sv
// Edge-aligned PWM with shadowed duty, per-period reload and dead-time insertion.
//   state | meaning
//   IDLE  | outputs off, counter held at 0, shadow still accepts new duty
//   RUN   | counter sweeps 0..period_latched, duty/period reload at wrap
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W,
  parameter int DT_W  = PWM_DT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  input  logic [CNT_W-1:0] period,
  input  logic [DT_W-1:0]  dead_time,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             period_start,
  output logic [CNT_W:0]   duty_active
);

  pwm_state_t       r_state;
  pwm_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_l;
  logic [CNT_W:0]   r_shadow;
  logic [CNT_W:0]   r_duty_active;
  logic [CNT_W:0]   w_duty_clamped;
  logic [CNT_W:0]   w_shadow_nxt;
  logic             w_start;
  logic             w_wrap;
  logic             w_raw;
  logic             w_stop;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (!enable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Duty above the period saturates at period+1, i.e. a solid 100% output.
  assign w_duty_clamped = (duty_in > period) ? ({1'b0, period} + {{CNT_W{1'b0}}, 1'b1})
                                             : {1'b0, duty_in};
  assign w_shadow_nxt   = duty_valid ? w_duty_clamped : r_shadow;
  assign w_wrap         = (r_state == RUN) && enable && (r_cnt == r_period_l);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_period_l    <= '0;
      r_shadow      <= '0;
      r_duty_active <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      if (w_start || w_wrap) begin
        r_cnt         <= '0;
        r_period_l    <= period;
        r_duty_active <= w_shadow_nxt;
      end else if ((r_state == RUN) && enable) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign w_raw  = (r_state == RUN) && ({1'b0, r_cnt} < r_duty_active);
  // Dropping enable kills the drivers on the very next edge, bypassing dead time.
  assign w_stop = (r_state != RUN) || !enable;

  pwm_deadtime #(
    .DT_W(DT_W)
  ) u_deadtime (
    .clk      (clk),
    .rst      (rst),
    .stop     (w_stop),
    .raw      (w_raw),
    .dead_time(dead_time),
    .hi       (pwm_hi),
    .lo       (pwm_lo)
  );

  assign period_start = (r_state == RUN) && (r_cnt == '0);
  assign duty_active  = r_duty_active;

endmodule

// File: tb/tb_pwm_driver.sv
// Directed bench for pwm_driver: per-scenario steady-state vector table plus corner sequences.
module tb_pwm_driver;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] duty_in;
  logic        duty_valid;
  logic [15:0] period;
  logic [7:0]  dead_time;
  logic        pwm_hi;
  logic        pwm_lo;
  logic        period_start;
  logic [16:0] duty_active;

  int n_cmp = 0;
  int n_err = 0;
  int both_hi = 0;

  pwm_driver #(.CNT_W(16), .DT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .period      (period),
    .dead_time   (dead_time),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .period_start(period_start),
    .duty_active (duty_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int period;
    int duty;
    int dt;
    int exp_da;
    int exp_hi;
    int exp_lo;
    int exp_bl;
    int exp_ps;
  } vec_t;

  vec_t vec[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pwm_hi && pwm_lo) both_hi++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int found;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (period_start) begin
        found = 1;
        break;
      end
      step();
    end
    check({name, "_timeout"}, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    int hi_c, lo_c, bl_c, ps_c;

    //          period duty dt  da  hi  lo  bl  ps  (10-cycle steady-state window)
    vec[0]  = '{9,  4,  0,  4,  4,  6,  0,  1};
    vec[1]  = '{9,  5,  2,  5,  3,  3,  4,  1};
    vec[2]  = '{9,  20, 3,  10, 10, 0,  0,  1};
    vec[3]  = '{9,  0,  2,  0,  0,  10, 0,  1};
    vec[4]  = '{0,  1,  0,  1,  10, 0,  0,  10};
    vec[5]  = '{0,  0,  1,  0,  0,  10, 0,  10};
    vec[6]  = '{4,  2,  1,  2,  2,  4,  4,  2};
    vec[7]  = '{4,  7,  0,  5,  10, 0,  0,  2};
    vec[8]  = '{9,  9,  1,  9,  8,  0,  2,  1};
    vec[9]  = '{9,  3,  5,  3,  0,  2,  8,  1};
    vec[10] = '{9,  10, 0,  10, 10, 0,  0,  1};

    rst = 1'b1;
    enable = 1'b0;
    duty_in = '0;
    duty_valid = 1'b0;
    period = '0;
    dead_time = '0;
    #12;
    check("reset_hi", int'(pwm_hi), 0);
    check("reset_lo", int'(pwm_lo), 0);
    check("reset_ps", int'(period_start), 0);
    check("reset_duty_active", int'(duty_active), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      do_reset();
      period = 16'(vec[i].period);
      dead_time = 8'(vec[i].dt);
      duty_in = 16'(vec[i].duty);
      duty_valid = 1'b1;
      step();
      duty_valid = 1'b0;
      enable = 1'b1;
      both_hi = 0;
      repeat (25) step();
      hi_c = 0; lo_c = 0; bl_c = 0; ps_c = 0;
      for (int k = 0; k < 10; k++) begin
        if (pwm_hi) hi_c++;
        if (pwm_lo) lo_c++;
        if (!pwm_hi && !pwm_lo) bl_c++;
        if (period_start) ps_c++;
        step();
      end
      check($sformatf("vec%0d_duty_active", i), int'(duty_active), vec[i].exp_da);
      check($sformatf("vec%0d_hi_cycles", i), hi_c, vec[i].exp_hi);
      check($sformatf("vec%0d_lo_cycles", i), lo_c, vec[i].exp_lo);
      check($sformatf("vec%0d_blank_cycles", i), bl_c, vec[i].exp_bl);
      check($sformatf("vec%0d_period_starts", i), ps_c, vec[i].exp_ps);
      check($sformatf("vec%0d_both_high", i), both_hi, 0);
      enable = 1'b0;
      step();
    end

    // Mid-period duty update waits for the wrap.
    do_reset();
    both_hi = 0;
    period = 16'd9;
    dead_time = 8'd0;
    duty_in = 16'd4;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    enable = 1'b1;
    repeat (15) step();
    wait_ps("shadow_sync");
    repeat (3) step();
    duty_in = 16'd7;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check("shadow_hold_cnt4", int'(duty_active), 4);
    repeat (5) step();
    check("shadow_hold_cnt9", int'(duty_active), 4);
    step();
    check("shadow_wrap_ps", int'(period_start), 1);
    check("shadow_applied", int'(duty_active), 7);
    hi_c = 0;
    for (int k = 0; k < 10; k++) begin
      if (pwm_hi) hi_c++;
      step();
    end
    check("shadow_hi_cycles", hi_c, 7);

    // duty_valid in the wrap cycle is applied at once.
    repeat (9) step();
    duty_in = 16'd2;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check("wrapcycle_ps", int'(period_start), 1);
    check("wrapcycle_duty_active", int'(duty_active), 2);

    // Disable at counter 6, then restart from counter 0.
    dead_time = 8'd2;
    duty_in = 16'd8;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    wait_ps("disable_sync");
    check("disable_duty_active", int'(duty_active), 8);
    repeat (6) step();
    check("disable_pre_hi", int'(pwm_hi), 1);
    enable = 1'b0;
    step();
    check("disable_hi", int'(pwm_hi), 0);
    check("disable_lo", int'(pwm_lo), 0);
    check("disable_ps", int'(period_start), 0);
    step();
    check("idle_hi", int'(pwm_hi), 0);
    check("idle_lo", int'(pwm_lo), 0);
    check("idle_ps", int'(period_start), 0);
    enable = 1'b1;
    step();
    check("restart_ps", int'(period_start), 1);
    check("restart_duty_active", int'(duty_active), 8);
    repeat (10) step();
    check("restart_ps_next", int'(period_start), 1);

    // Async reset mid-period.
    repeat (4) step();
    check("rst_pre_hi", int'(pwm_hi), 1);
    rst = 1'b1;
    #1;
    check("rst_async_hi", int'(pwm_hi), 0);
    check("rst_async_lo", int'(pwm_lo), 0);
    check("rst_async_ps", int'(period_start), 0);
    check("rst_async_duty_active", int'(duty_active), 0);
    #2;
    rst = 1'b0;
    step();
    check("rst_release_ps", int'(period_start), 1);
    check("rst_release_duty_active", int'(duty_active), 0);
    step();
    check("rst_release_lo", int'(pwm_lo), 1);
    check("rst_release_hi", int'(pwm_hi), 0);
    check("seq_both_high", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_driver.md
PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of duty, period and counter.
REQ-002 SHALL have parameter DT_W, default 8: width of dead-time value.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: run request; low forces a safe stop.
REQ-006 SHALL have port duty_in, input, CNT_W bits, unsigned: new duty (controller output), in counts.
REQ-007 SHALL have port duty_valid, input, 1 bit: single-cycle strobe qualifying duty_in.
REQ-008 SHALL have port period, input, CNT_W bits: PWM period minus 1, in clk cycles.
REQ-009 SHALL have port dead_time, input, DT_W bits: blanking cycles inserted at each output transition.
REQ-010 SHALL have port pwm_hi, output, 1 bit: high-side drive.
REQ-011 SHALL have port pwm_lo, output, 1 bit: low-side drive, complementary to pwm_hi.
REQ-012 SHALL have port period_start, output, 1 bit: one-cycle pulse when counter is 0 in RUN; the sampling tick for the controller.
REQ-013 SHALL have port duty_active, output, CNT_W+1 bits: duty currently applied.

Function
REQ-014 SHALL implement FSM states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE on the cycle after enable=0.
REQ-015 SHALL, in RUN, count 0..period_latched and wrap to 0; period_latched is loaded from period on IDLE->RUN and at every wrap.
REQ-016 SHALL treat period=0 as a 1-cycle PWM period, with period_start high every cycle.
REQ-017 SHALL capture duty_in into a shadow register on duty_valid, clamped to period+1 if duty_in > period (100%).
REQ-018 SHALL load duty_active from shadow at every wrap and on IDLE->RUN; a duty_valid in the wrap cycle takes effect immediately (new value wins).
REQ-019 SHALL compute raw = (counter < duty_active); duty 0 gives raw constantly 0, and period+1 gives raw constantly 1 with no transitions.
REQ-020 SHALL, on each raw edge, drive both outputs low for dead_time cycles and then assert the side matching raw.
REQ-021 SHALL, with dead_time=0, give pwm_hi=raw and pwm_lo=~raw with one register stage of latency.
REQ-022 SHALL, if raw toggles again during blanking, restart blanking; pwm_hi and pwm_lo are never simultaneously 1.
REQ-023 SHALL, in IDLE, hold pwm_hi=0, pwm_lo=0, counter=0 and period_start=0, while shadow keeps accepting duty_valid.
REQ-024 SHALL, on enable deasserted mid-period, force both outputs low on the next edge with no dead-time wait.

Reset
REQ-025 SHALL, with rst asserted, set state=IDLE, counter=0, shadow=0, duty_active=0, period_latched=0, blanking counter=0, pwm_hi=0, pwm_lo=0, period_start=0.
REQ-026 SHALL, on reset mid-period, take outputs low asynchronously; the first period after release starts at counter 0 once enable=1.

Structure
REQ-027 SHALL place the state enum and default CNT_W/DT_W constants in shared package pwm_pkg.
REQ-028 SHALL implement dead-time insertion as sub-module pwm_deadtime (inputs raw and dead_time; outputs hi and lo).

Verification
REQ-029 SHALL verify: period=9, duty 4, dead_time=0 -> pwm_hi high 4 of every 10 cycles; period_start every 10 cycles.
REQ-030 SHALL verify: duty_valid=7 at counter 3 -> duty_active stays 4 until the wrap, then 7 from the next period.
REQ-031 SHALL verify: dead_time=2, duty 5 of period 9 -> both low for 2 cycles at each edge; never both high.
REQ-032 SHALL verify: duty_in=20 with period=9 -> duty_active=10, pwm_hi constantly high and pwm_lo constantly low.
REQ-033 SHALL verify: enable=0 at counter 6 -> outputs 0 on the next edge, then IDLE; re-enable restarts at counter 0.
REQ-034 SHALL verify: rst pulse mid-period -> outputs 0 immediately, all registers 0, duty_active=0 after release.
